// File: rtl/exec_muldiv_if.sv
// Launch/complete handshake between the exec stage and the multi-cycle multiply/divide unit.
interface exec_muldiv_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned RD_W  = 5
);
   logic             enable;
   logic [1:0]       op;
   logic             sgn;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic [RD_W-1:0]  rd_in;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] data;
   logic [RD_W-1:0]  rd_out;

   modport master (
      output enable, op, sgn, rs, rt, rd_in, flush,
      input  busy, done, data, rd_out
   );

   modport slave (
      input  enable, op, sgn, rs, rt, rd_in, flush,
      output busy, done, data, rd_out
   );
endinterface

// File: rtl/exec_muldiv.sv
// Multi-cycle radix-2 multiply/divide unit: restoring divide, shift-add multiply,
// sign handled by magnitude arithmetic plus a final two's-complement fix-up.
module exec_muldiv #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned RD_W  = 5
) (
   input  logic         clk,
   input  logic         rstn,
   exec_muldiv_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned P_W   = 2 * WIDTH;
   localparam logic [1:0]  OP_DIV  = 2'b00;
   localparam logic [1:0]  OP_MOD  = 2'b01;
   localparam logic [1:0]  OP_MUL  = 2'b10;
   localparam logic [1:0]  OP_MULH = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t             r_state, w_next;
   logic [1:0]         r_op;
   logic               r_neg;
   logic               r_dz;
   logic [RD_W-1:0]    r_rd;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_hi;   // remainder (divide) / product high (multiply)
   logic [WIDTH-1:0]   r_lo;   // quotient (divide) / multiplier-then-product low (multiply)
   logic [WIDTH-1:0]   r_m;    // divisor or multiplicand magnitude
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_data;
   logic [RD_W-1:0]    r_rd_out;

   logic               w_accept;
   logic               w_fin;
   logic               w_is_div;
   logic               w_dz;
   logic [WIDTH-1:0]   w_rs_abs;
   logic [WIDTH-1:0]   w_rt_abs;
   logic [WIDTH:0]     w_mul_sum;
   logic [P_W-1:0]     w_mul_next;
   logic [WIDTH:0]     w_div_sh;
   logic [WIDTH:0]     w_div_diff;
   logic [P_W-1:0]     w_div_next;
   logic [P_W-1:0]     w_prod_s;
   logic [WIDTH-1:0]   w_quo_s;
   logic [WIDTH-1:0]   w_rem_s;
   logic [WIDTH-1:0]   w_res;

   assign w_is_div = ~bus.op[1];
   assign w_dz     = w_is_div && (bus.rt == '0);
   assign w_rs_abs = (bus.sgn && bus.rs[WIDTH-1]) ? (~bus.rs) + WIDTH'(1) : bus.rs;
   assign w_rt_abs = (bus.sgn && bus.rt[WIDTH-1]) ? (~bus.rt) + WIDTH'(1) : bus.rt;

   // Shift-add multiply step: add multiplicand on LSB, shift the pair right
   assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
   assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};

   // Restoring divide step: shift next dividend bit into remainder, trial subtract
   assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
   assign w_div_diff = w_div_sh - {1'b0, r_m};
   assign w_div_next = w_div_diff[WIDTH] ? {w_div_sh[WIDTH-1:0], r_lo[WIDTH-2:0], 1'b0}
                                         : {w_div_diff[WIDTH-1:0], r_lo[WIDTH-2:0], 1'b1};

   assign w_prod_s = r_neg ? (~{r_hi, r_lo}) + P_W'(1) : {r_hi, r_lo};
   assign w_quo_s  = r_neg ? (~r_lo) + WIDTH'(1) : r_lo;
   assign w_rem_s  = r_neg ? (~r_hi) + WIDTH'(1) : r_hi;

   always_comb begin
      w_res = '0;
      case (r_op)
         OP_DIV:  w_res = r_dz ? '1 : w_quo_s;
         OP_MOD:  w_res = r_dz ? r_lo : w_rem_s;
         OP_MUL:  w_res = w_prod_s[WIDTH-1:0];
         OP_MULH: w_res = w_prod_s[P_W-1:WIDTH];
         default: w_res = '0;
      endcase
   end

   // Next-state and control strobes; flush wins over launch and completion
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_fin    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.enable && !bus.flush) begin
               w_accept = 1'b1;
               w_next   = w_dz ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            if (bus.flush)          w_next = S_IDLE;
            else if (r_cnt == '0)   w_next = S_FIX;
         end
         S_FIX: begin
            w_next = S_IDLE;
            w_fin  = ~bus.flush;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_op  <= '0;
         r_neg <= 1'b0;
         r_dz  <= 1'b0;
         r_rd  <= '0;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_m   <= '0;
      end else if (w_accept) begin
         r_op  <= bus.op;
         r_dz  <= w_dz;
         r_rd  <= bus.rd_in;
         r_cnt <= CNT_W'(WIDTH - 1);
         r_hi  <= '0;
         r_lo  <= w_dz ? bus.rs : (w_is_div ? w_rs_abs : w_rt_abs);
         r_m   <= w_is_div ? w_rt_abs : w_rs_abs;
         r_neg <= bus.sgn & ((bus.op == OP_MOD) ? bus.rs[WIDTH-1]
                                                : (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]));
      end else if (r_state == S_CALC) begin
         if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
         {r_hi, r_lo} <= r_op[1] ? w_mul_next : w_div_next;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_data   <= '0;
         r_rd_out <= '0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= w_fin;
         if (w_fin) begin
            r_data   <= w_res;
            r_rd_out <= r_rd;
         end
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.data   = r_data;
   assign bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv: arithmetic results, latency, tag, busy/flush/reset behaviour.
module tb_exec_muldiv;
   localparam int unsigned W = 32;
   localparam logic [1:0] DIV = 2'b00, MOD = 2'b01, MUL = 2'b10, MULH = 2'b11;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_err;
   int   lat;
   int   n_done;

   exec_muldiv_if #(.WIDTH(W), .RD_W(5)) bus ();

   exec_muldiv #(.WIDTH(W), .RD_W(5)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [1:0] op, input logic sgn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] rd);
      bus.enable = 1'b1;
      bus.op     = op;
      bus.sgn    = sgn;
      bus.rs     = rs;
      bus.rt     = rt;
      bus.rd_in  = rd;
      tick();
      bus.enable = 1'b0;
   endtask

   // Returns number of edges after the accept edge until done is seen, -1 on timeout
   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic sgn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      launch(op, sgn, rs, rt, rd);
      wait_done(lat);
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " data"}, 64'(bus.data), 64'(exp));
      chk({tag, " rd_out"}, 64'(bus.rd_out), 64'(rd));
      chk({tag, " busy"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rstn = 1'b0;
      bus.enable = 1'b0;
      bus.op = DIV;
      bus.sgn = 1'b0;
      bus.rs = '0;
      bus.rt = '0;
      bus.rd_in = '0;
      bus.flush = 1'b0;
      tick();
      tick();
      chk("reset busy", 64'(bus.busy), 64'(0));
      chk("reset done", 64'(bus.done), 64'(0));
      chk("reset data", 64'(bus.data), 64'(0));
      chk("reset rd_out", 64'(bus.rd_out), 64'(0));
      rstn = 1'b1;
      tick();

      run_op("divu 100/7", DIV, 1'b0, 32'd100, 32'd7, 5'd3, 32'd14, 33);
      tick();
      chk("done one cycle", 64'(bus.done), 64'(0));
      run_op("modu 100/7", MOD, 1'b0, 32'd100, 32'd7, 5'd4, 32'd2, 33);
      run_op("divs -7/2", DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
      run_op("mods -7/2", MOD, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);

      run_op("div by 0", DIV, 1'b0, 32'h0000_1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
      run_op("mod by 0", MOD, 1'b0, 32'h0000_1234, 32'd0, 5'd8, 32'h0000_1234, 1);
      run_op("mods by 0", MOD, 1'b1, 32'h8000_0005, 32'd0, 5'd9, 32'h8000_0005, 1);
      run_op("divs ovf", DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 33);
      run_op("mods ovf", MOD, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 33);

      run_op("muls -1*-1", MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'd1, 33);
      run_op("mulhs -1*-1", MULH, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'd0, 33);
      run_op("mulu max*max", MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'd1, 33);
      run_op("mulhu max*max", MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 33);
      run_op("mulu 12345*678", MUL, 1'b0, 32'd12345, 32'd678, 5'd16, 32'd8369910, 33);
      run_op("muls -3*5", MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 5'd17, 32'hFFFF_FFF1, 33);
      run_op("mulhs -3*5", MULH, 1'b1, 32'hFFFF_FFFD, 32'd5, 5'd18, 32'hFFFF_FFFF, 33);

      // Enable while busy must be ignored
      launch(DIV, 1'b0, 32'd100, 32'd7, 5'd20);
      repeat (4) tick();
      launch(MUL, 1'b0, 32'd3, 32'd3, 5'd21);
      wait_done(lat);
      chk("ignored en latency", 64'(lat), 64'(28));
      chk("ignored en data", 64'(bus.data), 64'(14));
      chk("ignored en rd_out", 64'(bus.rd_out), 64'(20));
      // Back-to-back launch in the done cycle
      launch(MUL, 1'b0, 32'd6, 32'd7, 5'd22);
      chk("b2b busy", 64'(bus.busy), 64'(1));
      wait_done(lat);
      chk("b2b latency", 64'(lat), 64'(33));
      chk("b2b data", 64'(bus.data), 64'(42));
      chk("b2b rd_out", 64'(bus.rd_out), 64'(22));

      // Flush mid-operation
      launch(DIV, 1'b0, 32'd1000, 32'd3, 5'd23);
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush busy", 64'(bus.busy), 64'(0));
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done === 1'b1) n_done++;
      end
      chk("flush no done", 64'(n_done), 64'(0));
      chk("flush data held", 64'(bus.data), 64'(42));
      chk("flush rd held", 64'(bus.rd_out), 64'(22));

      // Flush with enable in idle drops the launch
      bus.flush = 1'b1;
      launch(MUL, 1'b0, 32'd2, 32'd2, 5'd24);
      bus.flush = 1'b0;
      chk("flush+en busy", 64'(bus.busy), 64'(0));

      // Asynchronous reset mid-operation
      launch(MUL, 1'b0, 32'd9, 32'd9, 5'd25);
      repeat (4) tick();
      rstn = 1'b0;
      #1;
      chk("rst mid busy", 64'(bus.busy), 64'(0));
      chk("rst mid done", 64'(bus.done), 64'(0));
      chk("rst mid data", 64'(bus.data), 64'(0));
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done === 1'b1) n_done++;
      end
      chk("rst no done", 64'(n_done), 64'(0));
      rstn = 1'b1;
      tick();
      run_op("after reset", MUL, 1'b0, 32'd6, 32'd7, 5'd26, 32'd42, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
